// File: rtl/vga_frame_sequencer.sv
// VGA raster timing generator with a one-cycle registered colour/sync stage
// and frame-aligned test-pattern selection (manual advance or auto cycling).
module vga_frame_sequencer #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter int unsigned FRAMES_PER_PAT = 120,
    parameter int unsigned NUM_PATTERNS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       auto_en,
    input  logic [3:0] pat_red,
    input  logic [3:0] pat_green,
    input  logic [3:0] pat_blue,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [1:0] pattern_sel,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned FC_W     = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [FC_W-1:0]  frame_cnt;
    logic             pending;
    logic             primed;

    logic             active_c;
    logic             h_wrap_c;
    logic             frame_end_c;
    logic             step_c;
    logic             hsync_c;
    logic             vsync_c;
    logic [1:0]       pattern_next_c;

    assign x = h;
    assign y = v;

    // Raster decode and step decision for the current position.
    always_comb begin
        active_c       = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
        h_wrap_c       = (h == CNT_W'(H_TOTAL - 1));
        frame_end_c    = h_wrap_c && (v == CNT_W'(V_TOTAL - 1));
        step_c         = pending || advance ||
                         (auto_en && (frame_cnt == FC_W'(FRAMES_PER_PAT - 1)));
        hsync_c        = !((h >= CNT_W'(HS_FIRST)) && (h <= CNT_W'(HS_LAST)));
        vsync_c        = !((v >= CNT_W'(VS_FIRST)) && (v <= CNT_W'(VS_LAST)));
        pattern_next_c = (pattern_sel == 2'(NUM_PATTERNS - 1)) ? 2'd0 : pattern_sel + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap_c) begin
            h <= '0;
            v <= (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    // Pattern selection only moves on the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_sel <= 2'd0;
            frame_cnt   <= '0;
            pending     <= 1'b0;
            primed      <= 1'b0;
        end else if (frame_end_c) begin
            primed <= 1'b1;
            if (step_c) begin
                pattern_sel <= pattern_next_c;
                frame_cnt   <= '0;
                pending     <= 1'b0;
            end else begin
                frame_cnt <= auto_en ? frame_cnt + FC_W'(1) : '0;
            end
        end else if (advance) begin
            pending <= 1'b1;
        end
    end

    // The first frame after reset is partial from the sink's view, so frame_start waits for the second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_red     <= 4'h0;
            vga_green   <= 4'h0;
            vga_blue    <= 4'h0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_red     <= active_c ? pat_red   : 4'h0;
            vga_green   <= active_c ? pat_green : 4'h0;
            vga_blue    <= active_c ? pat_blue  : 4'h0;
            hsync       <= hsync_c;
            vsync       <= vsync_c;
            frame_start <= primed && (h == '0) && (v == '0);
        end
    end
endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer on a shrunken raster; expectations come from
// cycle-count arithmetic and a frame-level pattern model.
module tb_vga_frame_sequencer;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FPP = 3, NP = 4;
    localparam logic [36:0] RST_VEC = {10'd0, 10'd0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0};

    logic       clk, rst, advance, auto_en;
    logic [3:0] pat_red, pat_green, pat_blue;
    logic [9:0] x, y, x1, y1;
    logic [1:0] pattern_sel, pattern_sel1;
    logic [3:0] vga_red, vga_green, vga_blue, red1, green1, blue1;
    logic       hsync, vsync, frame_start, hsync1, vsync1, frame_start1;

    logic        mode;
    logic [11:0] seed;
    int          total, bad;

    // Reference state: cycles since reset release plus frame-level pattern bookkeeping.
    int          t;
    logic [1:0]  m_pat;
    logic        m_pend;
    int          m_cnt;

    logic [9:0]  e_x, e_y;
    logic [11:0] e_vga;
    logic        e_hs, e_vs, e_fs;
    int          ep, eph, epv;
    logic [36:0] obs, obs1, expv, expv1;
    logic [11:0] pat_all;

    function automatic logic [11:0] colour(int hh, int vv, logic md, logic [11:0] sd);
        if (md) return 12'hFFF;
        return 12'(hh * 37 + vv * 211) ^ sd;
    endfunction

    assign pat_all = colour(int'(x), int'(y), mode, seed);
    assign {pat_red, pat_green, pat_blue} = pat_all;

    vga_frame_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FRAMES_PER_PAT(FPP), .NUM_PATTERNS(NP)
    ) dut (
        .clk(clk), .rst(rst), .advance(advance), .auto_en(auto_en),
        .pat_red(pat_red), .pat_green(pat_green), .pat_blue(pat_blue),
        .x(x), .y(y), .pattern_sel(pattern_sel),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    vga_frame_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FRAMES_PER_PAT(FPP), .NUM_PATTERNS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .advance(advance), .auto_en(auto_en),
        .pat_red(pat_red), .pat_green(pat_green), .pat_blue(pat_blue),
        .x(x1), .y(y1), .pattern_sel(pattern_sel1),
        .vga_red(red1), .vga_green(green1), .vga_blue(blue1),
        .hsync(hsync1), .vsync(vsync1), .frame_start(frame_start1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t      <= 0;
            m_pat  <= 2'd0;
            m_pend <= 1'b0;
            m_cnt  <= 0;
        end else begin
            t <= t + 1;
            if (t % FT == FT - 1) begin
                if (m_pend || advance || (auto_en && m_cnt == FPP - 1)) begin
                    m_pat  <= 2'((int'(m_pat) + 1) % NP);
                    m_pend <= 1'b0;
                    m_cnt  <= 0;
                end else begin
                    m_cnt <= auto_en ? m_cnt + 1 : 0;
                end
            end else if (advance) begin
                m_pend <= 1'b1;
            end
        end
    end

    // Registered outputs describe the raster position one cycle earlier.
    always_comb begin
        ep    = 0;
        eph   = 0;
        epv   = 0;
        e_x   = 10'(t % HT);
        e_y   = 10'((t / HT) % VT);
        e_vga = 12'h000;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_fs  = 1'b0;
        if (t >= 1) begin
            ep  = t - 1;
            eph = ep % HT;
            epv = (ep / HT) % VT;
            if (eph < HA && epv < VA) e_vga = colour(eph, epv, mode, seed);
            e_hs = !(eph >= HA + HF && eph < HA + HF + HS);
            e_vs = !(epv >= VA + VF && epv < VA + VF + VS);
            e_fs = (ep >= FT) && (ep % FT == 0);
        end
    end

    assign obs   = {x, y, pattern_sel, vga_red, vga_green, vga_blue, hsync, vsync, frame_start};
    assign expv  = {e_x, e_y, m_pat, e_vga, e_hs, e_vs, e_fs};
    assign obs1  = {x1, y1, pattern_sel1, red1, green1, blue1, hsync1, vsync1, frame_start1};
    assign expv1 = {e_x, e_y, 2'd0, e_vga, e_hs, e_vs, e_fs};

    task automatic do_reset(input logic md);
        rst     = 1'b1;
        advance = 1'b0;
        mode    = md;
        seed    = 12'($urandom);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; advance = 1'b0; auto_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== RST_VEC) begin
                bad++;
                $display("FAIL reset_hold got=%h exp=%h", obs, RST_VEC);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (x !== 10'd1 || y !== 10'd0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got x=%0d y=%0d fs=%b exp x=1 y=0 fs=0", x, y, frame_start);
        end
    endtask

    task automatic test_timing();
        int hs_low, vs_low, fs_cnt, fs_first, fs_last;
        hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = 0; fs_last = 0;
        do_reset(1'b0);
        for (int i = 0; i < 2 * FT + 2; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL timing_cycle t=%0d got=%h exp=%h", t, obs, expv);
            end
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_start) begin
                if (fs_cnt == 0) fs_first = t;
                fs_last = t;
                fs_cnt++;
            end
        end
        total++;
        if (hs_low != 2 * VT * HS) begin
            bad++;
            $display("FAIL timing_hsync_low got=%0d exp=%0d", hs_low, 2 * VT * HS);
        end
        total++;
        if (vs_low != 2 * VS * HT) begin
            bad++;
            $display("FAIL timing_vsync_low got=%0d exp=%0d", vs_low, 2 * VS * HT);
        end
        total++;
        if (fs_cnt != 2 || fs_first != FT + 1 || fs_last - fs_first != FT) begin
            bad++;
            $display("FAIL timing_frame_start got cnt=%0d first=%0d period=%0d exp cnt=2 first=%0d period=%0d",
                     fs_cnt, fs_first, fs_last - fs_first, FT + 1, FT);
        end
    endtask

    task automatic test_blanking();
        int lit [VT];
        int row;
        for (int r = 0; r < VT; r++) lit[r] = 0;
        do_reset(1'b1);
        for (int i = 0; i < FT; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL blank_cycle t=%0d got=%h exp=%h", t, obs, expv);
            end
            row = ((t - 1) / HT) % VT;
            if ({vga_red, vga_green, vga_blue} == 12'hFFF) lit[row]++;
        end
        for (int r = 0; r < VT; r++) begin
            total++;
            if (lit[r] != ((r < VA) ? HA : 0)) begin
                bad++;
                $display("FAIL blank_line row=%0d got=%0d exp=%0d", r, lit[r], (r < VA) ? HA : 0);
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_advance_collapse();
        int a1, a2, a3;
        int exp_ps;
        do_reset(1'b0);
        auto_en = 1'b0;
        a1 = 3 * HT + int'($urandom_range(0, 3));
        a2 = a1 + 2 + int'($urandom_range(0, 3));
        a3 = a2 + 2 + int'($urandom_range(0, 3));
        for (int i = 0; i < 2 * FT + 1; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL collapse_cycle t=%0d got=%h exp=%h", t, obs, expv);
            end
            exp_ps = (t < FT) ? 0 : 1;
            total++;
            if (int'(pattern_sel) != exp_ps) begin
                bad++;
                $display("FAIL collapse_pattern t=%0d got=%0d exp=%0d", t, pattern_sel, exp_ps);
            end
            advance = (t == a1) || (t == a2) || (t == a3);
        end
        advance = 1'b0;
    endtask

    task automatic test_wrap();
        int seq [4] = '{1, 2, 3, 0};
        int adv_t;
        do_reset(1'b0);
        auto_en = 1'b0;
        for (int f = 0; f < 4; f++) begin
            adv_t = f * FT + int'($urandom_range(1, FT - 3));
            for (int i = 0; i < FT; i++) begin
                @(negedge clk);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL wrap_cycle t=%0d got=%h exp=%h", t, obs, expv);
                end
                advance = (t == adv_t);
            end
            total++;
            if (int'(pattern_sel) != seq[f]) begin
                bad++;
                $display("FAIL wrap_step frame=%0d got=%0d exp=%0d", f, pattern_sel, seq[f]);
            end
        end
    endtask

    task automatic test_boundary();
        int exp_ps;
        for (int i = 0; i < 2 * FT; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL boundary_cycle t=%0d got=%h exp=%h", t, obs, expv);
            end
            if (t == 5 * FT - 1 || t == 5 * FT || t == 6 * FT) begin
                exp_ps = (t < 5 * FT) ? 0 : 1;
                total++;
                if (int'(pattern_sel) != exp_ps) begin
                    bad++;
                    $display("FAIL boundary_step t=%0d got=%0d exp=%0d", t, pattern_sel, exp_ps);
                end
            end
            advance = (t % FT == FT - 1) && (t < 5 * FT);
        end
        advance = 1'b0;
    endtask

    task automatic test_auto();
        int tbl [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};
        do_reset(1'b0);
        auto_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            for (int i = 0; i < FT; i++) begin
                @(negedge clk);
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL auto_cycle t=%0d got=%h exp=%h", t, obs, expv);
                end
                if (t == 8 * FT + 1) auto_en = 1'b0;
                if (t == 9 * FT + 1) auto_en = 1'b1;
            end
            total++;
            if (int'(pattern_sel) != tbl[k - 1]) begin
                bad++;
                $display("FAIL auto_step frame_end=%0d got=%0d exp=%0d", k, pattern_sel, tbl[k - 1]);
            end
        end
        auto_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset(1'b0);
        auto_en = 1'b0;
        for (int i = 0; i < 6 * FT; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_cycle t=%0d got=%h exp=%h", t, obs, expv);
            end
            total++;
            if (obs1 !== expv1) begin
                bad++;
                $display("FAIL single_pattern t=%0d got=%h exp=%h", t, obs1, expv1);
            end
            advance = ($urandom_range(0, 63) == 0) ||
                      ((t % FT == FT - 1) && ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
        end
        advance = 1'b0;
        auto_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int target;
        target = (VT / 2) * HT + HT / 2;
        do_reset(1'b0);
        auto_en = 1'b0;
        for (int i = 0; i < FT; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL midreset_pre t=%0d got=%h exp=%h", t, obs, expv);
            end
            advance = (t == target - 4);
            if (t == target) break;
        end
        advance = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL midreset_immediate got=%h exp=%h", obs, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FT + 2; i++) begin
            @(negedge clk);
            total++;
            if (obs !== expv || pattern_sel !== 2'd0) begin
                bad++;
                $display("FAIL midreset_post t=%0d got=%h exp=%h", t, obs, expv);
            end
        end
    endtask

    initial begin
        rst = 1'b1; advance = 1'b0; auto_en = 1'b0;
        mode = 1'b0; seed = 12'($urandom);
        total = 0; bad = 0;
        test_reset();
        test_timing();
        test_blanking();
        test_advance_collapse();
        test_wrap();
        test_boundary();
        test_auto();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_frame_sequencer.md
VGA_FRAME_SEQUENCER -- requirements
Module: vga_frame_sequencer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FRAMES_PER_PAT, 120, frames per pattern in auto mode
- NUM_PATTERNS, 4, pattern count; range 1..4
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, pixel clock
- rst, in, 1, reset
- advance, in, 1, synchronous request to step to the next pattern
- auto_en, in, 1, automatic pattern cycling enable
- pat_red, pat_green, pat_blue, in, 4 each, colour from the external pattern generator for the current x/y
- x, out, 10, current horizontal count
- y, out, 10, current vertical count
- pattern_sel, out, 2, selected pattern index
- vga_red, vga_green, vga_blue, out, 4 each, registered pixel colour
- hsync, vsync, out, 1 each, active-low sync pulses
- frame_start, out, 1, one-cycle pulse on the first pixel of a frame
REQ-003 The block SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 The horizontal counter SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters, 800 by default) and wrap to 0.
REQ-005 The vertical counter SHALL increment when the horizontal counter wraps, run 0..V_TOTAL-1 (525 by default), and wrap to 0.
REQ-006 x and y SHALL equal the horizontal and vertical counters combinationally, with zero latency.
REQ-007 active SHALL be true when h < H_ACTIVE and v < V_ACTIVE.
REQ-008 The output stage SHALL be registered with 1-cycle latency from x/y: the vga_* outputs SHALL carry the pat_* values when active and 4'h0 otherwise.
REQ-009 hsync SHALL be 0 exactly when the registered h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751; it SHALL be 1 otherwise. hsync SHALL be pipelined alongside the colour outputs.
REQ-010 vsync SHALL be 0 exactly when the registered v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491; it SHALL be 1 otherwise. vsync SHALL be pipelined alongside the colour outputs.
REQ-011 frame_start SHALL be 1 for exactly the single cycle in which the registered outputs correspond to h=0, v=0.
REQ-012 frame_end SHALL be the cycle with h=H_TOTAL-1 and v=V_TOTAL-1. pattern_sel SHALL change only on frame_end, so it never changes mid-frame.
REQ-013 An advance pulse SHALL set a pending flag. Multiple pulses before frame_end SHALL collapse into one step.
REQ-014 At frame_end, the block SHALL step when (pending OR advance OR (auto_en AND frame_cnt = FRAMES_PER_PAT-1)). A step SHALL:
- set pattern_sel to (pattern_sel+1) mod NUM_PATTERNS
- clear pending
- clear frame_cnt
REQ-015 At frame_end without a step, frame_cnt SHALL increment if auto_en=1 and SHALL clear if auto_en=0.
REQ-016 advance asserted in the frame_end cycle itself SHALL step at that boundary and SHALL NOT leave pending set.
REQ-017 With NUM_PATTERNS=1, pattern_sel SHALL stay 0.
REQ-018 frame_cnt SHALL be ceil(log2(FRAMES_PER_PAT)) bits wide and SHALL never exceed FRAMES_PER_PAT-1.

Reset
REQ-019 While rst=1, the block SHALL hold:
- h=0, v=0, frame_cnt=0, pending=0, pattern_sel=0
- vga_* = 0, hsync=1, vsync=1, frame_start=0
REQ-020 Reset asserted mid-line or mid-frame SHALL take effect immediately, with a pending advance discarded.
REQ-021 After rst deasserts, the first clk edge SHALL advance h to 1. frame_start SHALL first pulse when h=0, v=0 is next output, i.e. at the start of the second frame.

Verification
REQ-022 Timing check: reset, then run 2 frames. Required response:
- hsync low 96 cycles every 800
- vsync low 2 lines (1600 cycles) every 525 lines
- frame_start period 420000 cycles
REQ-023 Blanking check: drive pat_*=4'hF constantly. Required response:
- vga_* = F for 640 of 800 cycles on lines 0..479
- vga_* = 0 on lines 480..524
REQ-024 Advance collapse: auto_en=0; pulse advance 3 times at v=100. Required response:
- pattern_sel goes 0->1 exactly at frame_end, not before
- pattern_sel stays 1 through the next frame
REQ-025 Wrap and boundary timing with NUM_PATTERNS=4:
- advance once per frame for 4 frames: pattern_sel sequence 1,2,3,0
- advance on the frame_end cycle: step occurs at that boundary, and no further step at the next boundary
REQ-026 Auto mode: auto_en=1 with FRAMES_PER_PAT=3. Required response:
- pattern_sel steps every 3rd frame_end
- auto_en dropped at frame_cnt=2, then raised again: the count restarts from 0
REQ-027 Reset mid-frame: assert rst at h=300, v=200 with pending set. Required response:
- all outputs take reset values within the same cycle
- after release, no step occurs at the first frame_end
